// File: rtl/opl3_host_if.sv
// -----------------------------------------------------------------------------
// opl3_host_if
//
// Host-side front end for the OPL3 register-decode blocks. The host writes a
// register address (address phase) and then one or more data bytes (data
// phase). Every accepted data byte becomes one buffered register write
// {bank, address, data}. The writes are replayed in order as single-cycle
// pulses on opl3_reg_wr. Consecutive pulses are always at least
// WR_GAP_CYCLES clocks apart, and exactly that far apart while the buffer
// stays non-empty.
//
// Parameters
//   FIFO_DEPTH     buffered register writes (power of 2, >= 2)
//   WR_GAP_CYCLES  minimum clocks between opl3_reg_wr valid pulses (>= 1)
//
// Ports
//   clk          system clock
//   ic_n         synchronous active-low reset
//   host_wr      host write strobe, one write per cycle while high
//   host_addr    [0]: 0 = address phase, 1 = data phase
//                [1]: bank select (used in the address phase only)
//   host_data    register address (address phase) or data (data phase)
//   host_ready   high when a data-phase write would be accepted
//   overflow     sticky: a data-phase write arrived while the FIFO was full
//   opl3_reg_wr  packed register write; same layout as the packed struct
//                {valid, bank_num, address[7:0], data[7:0]}:
//                  [17] valid  [16] bank_num  [15:8] address  [7:0] data
//                bank_num/address/data hold their last value while valid
//                is low, so consumers must qualify on valid.
// -----------------------------------------------------------------------------
module opl3_host_if #(
  parameter int FIFO_DEPTH    = 8,
  parameter int WR_GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        ic_n,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic        overflow,
  output logic [17:0] opl3_reg_wr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (WR_GAP_CYCLES > 2) ? $clog2(WR_GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // FIFO storage: {bank, address, data}
  logic [16:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // Address latched by the most recent address phase
  logic [7:0]       lat_addr;
  logic             lat_bank;

  // Replay FSM and registered output fields
  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             out_valid;
  logic             out_bank;
  logic [7:0]       out_addr;
  logic [7:0]       out_data;

  logic             data_wr;
  logic             push;
  logic             pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign data_wr = host_wr && host_addr[0];

  // Fullness is taken from the registered count, so a pop on the same edge
  // never makes room for this push.
  assign push = ic_n && data_wr && !full;

  // A pop happens on the edge where the FSM is allowed to start a new pulse.
  // With a gap of one clock, ISSUE chains straight into the next entry so
  // pulses can run back-to-back.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      ISSUE:   pop = (WR_GAP_CYCLES == 1) && !empty;
      default: pop = 1'b0;
    endcase
  end

  assign host_ready  = !full && ic_n;
  assign opl3_reg_wr = {out_valid, out_bank, out_addr, out_data};

  // Storage array carries data only; emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {lat_bank, lat_addr, host_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      lat_addr  <= 8'h00;
      lat_bank  <= 1'b0;
      state     <= IDLE;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_bank  <= 1'b0;
      out_addr  <= 8'h00;
      out_data  <= 8'h00;
    end else begin
      // Address phase is always taken, even with the FIFO full.
      if (host_wr && !host_addr[0]) begin
        lat_addr <= host_data;
        lat_bank <= host_addr[1];
      end

      if (data_wr && full) begin
        overflow <= 1'b1;
      end

      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        {out_bank, out_addr, out_data} <= mem[rd_ptr];
      end

      case (state)
        IDLE: begin
          if (pop) begin
            out_valid <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (pop) begin
            // Gap of one clock: next entry goes out immediately.
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            if (WR_GAP_CYCLES > 2) begin
              gap_cnt <= GAP_W'(WR_GAP_CYCLES - 2);
              state   <= HOLDOFF;
            end else begin
              state <= IDLE;
            end
          end
        end

        HOLDOFF: begin
          // Return to IDLE on the edge where the count reaches zero, so the
          // next IDLE pop lands exactly WR_GAP_CYCLES after the previous one.
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) begin
            state <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
